// File: rtl/ram_burst_engine_pkg.sv
// Shared definitions for the RAM burst engine: default widths,
// rw/op encodings and the sequencer state type.
package ram_burst_engine_pkg;

  localparam int ADDR_W_DEF     = 23;
  localparam int DATA_W_DEF     = 32;
  localparam int LEN_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic OP_READ = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FILL   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram_stream_fifo.sv
// Synchronous read-return FIFO (async reset). Ports: push/push_data in,
// pop/pop_data out (head word), count/empty/full status.
module ram_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ram_burst_engine.sv
// Burst sequencer: accepts cmd (op/addr/len/data), issues RAM accesses
// (addr/rw/data_in/in_valid vs busy), streams reads out via dout ready/valid.
module ram_burst_engine
  import ram_burst_engine_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] data_in,
  output logic              in_valid,
  input  logic              busy,
  input  logic [DATA_W-1:0] data_out,
  input  logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              active,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  remaining;
  logic [CW-1:0]     in_flight;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW:0]       occupancy;
  logic              credit_ok;
  logic              rd_issue;
  logic              wr_issue;
  logic              ret;

  // Words already queued plus words still on their way back must
  // fit in the FIFO, so a read is only issued with a free slot.
  assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight};
  assign credit_ok = !fifo_full
                  && (occupancy < (CW+1)'(FIFO_DEPTH));

  assign rd_issue = (state == ST_READ) && !busy
                 && (remaining != '0) && credit_ok;
  assign wr_issue = (state == ST_FILL) && !busy
                 && (remaining != '0);

  // Returns with nothing outstanding (stale after reset) are dropped.
  assign ret = out_valid && (in_flight != '0);

  assign in_valid  = rd_issue || wr_issue;
  assign addr      = cur;
  assign cmd_ready = (state == ST_IDLE);
  assign active    = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign dout_valid = !fifo_empty;

  ram_stream_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret),
    .push_data (data_out),
    .pop       (dout_ready),
    .pop_data  (dout),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur       <= '0;
      remaining <= '0;
      in_flight <= '0;
      rw        <= RW_READ;
      data_in   <= '0;
    end else begin
      in_flight <= in_flight + CW'(rd_issue) - CW'(ret);
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur       <= cmd_addr;
            remaining <= cmd_len;
            data_in   <= cmd_data;
            rw        <= (cmd_op == OP_FILL) ? RW_WRITE : RW_READ;
            if (cmd_len == '0) begin
              state <= ST_FINISH;
            end else if (cmd_op == OP_FILL) begin
              state <= ST_FILL;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            cur       <= cur + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
          end
          if ((remaining == '0) && (in_flight == '0)) begin
            state <= ST_FINISH;
          end
        end
        ST_FILL: begin
          if (wr_issue) begin
            cur       <= cur + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
          end
          if (remaining == '0) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_engine.sv
// Testbench for ram_burst_engine: model RAM with configurable latency,
// reference memory and expected-stream queues, table plus random vectors.
module tb_ram_burst_engine;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [22:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [31:0] cmd_data;
  logic [22:0] addr;
  logic        rw;
  logic [31:0] data_in;
  logic        in_valid;
  logic        busy;
  logic [31:0] data_out;
  logic        out_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        active;
  logic        done;

  ram_burst_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .addr       (addr),
    .rw         (rw),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .busy       (busy),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .active     (active),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [22:0] addr;
    int          len;
    logic [31:0] data;
    int          busy_pct;
    int          ready_pct;
    int          hold;
    int          exp_hold_issued;
    bit          keep_valid;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] d;
  } resp_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [31:0] mem [bit [22:0]];
  logic [22:0] exp_addr_q [$];
  logic [31:0] exp_dout_q [$];
  resp_t       resp_q [$];

  int   lat = 1;
  int   busy_pct = 0;
  int   ready_pct = 100;
  int   hold_left = 0;
  logic cur_op = 1'b0;
  logic [31:0] cur_pattern = '0;
  int   issued, done_cnt, acc_cnt;
  int   acc_cyc, first_issue_cyc, done_cyc;

  vec_t vt [30];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return ({9'h0, a} * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic clear_burst();
    issued = 0;
    done_cnt = 0;
    acc_cnt = 0;
    acc_cyc = -1;
    first_issue_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic on_accept();
    logic [22:0] a;
    for (int i = 0; i < int'(cmd_len); i++) begin
      a = cmd_addr + 23'(i);
      exp_addr_q.push_back(a);
      if (cmd_op == 1'b0) exp_dout_q.push_back(memrd(a));
    end
  endtask

  // One clock: observe at negedge, then drive new inputs after posedge.
  task automatic cycle();
    logic [22:0] ea;
    logic [31:0] ed;
    resp_t r;
    @(negedge clk);
    if (in_valid) begin
      if (busy) chk("in_valid_while_busy", 1, 0);
      issued++;
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_access", 1, 0);
      end else begin
        ea = exp_addr_q.pop_front();
        chk("access_addr", addr, ea);
      end
      chk("access_rw", rw, cur_op);
      if (rw) begin
        chk("fill_data", data_in, cur_pattern);
        mem[addr] = data_in;
      end else begin
        resp_q.push_back('{cyc + lat, memrd(addr)});
      end
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
      on_accept();
    end
    if (dout_valid && dout_ready) begin
      if (exp_dout_q.size() == 0) begin
        chk("unexpected_dout", 1, 0);
      end else begin
        ed = exp_dout_q.pop_front();
        chk("dout", dout, ed);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    out_valid = 1'b0;
    data_out  = '0;
    if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
      r = resp_q.pop_front();
      out_valid = 1'b1;
      data_out  = r.d;
    end
    busy = ($urandom_range(99) < busy_pct);
    if (hold_left > 0) begin
      hold_left--;
      dout_ready = 1'b0;
    end else begin
      dout_ready = ($urandom_range(99) < ready_pct);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int n;
    clear_burst();
    busy_pct    = v.busy_pct;
    ready_pct   = v.ready_pct;
    cur_op      = v.op;
    cur_pattern = v.data;
    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_addr    = v.addr;
    cmd_len     = 16'(v.len);
    cmd_data    = v.data;
    if (v.hold > 0) begin
      dout_ready = 1'b0;
      hold_left  = 1000;
    end
    n = 0;
    while (acc_cnt == 0 && n < 50) begin
      cycle();
      n++;
    end
    if (!v.keep_valid) cmd_valid = 1'b0;
    if (acc_cnt == 0) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      hold_left = 0;
      return;
    end
    if (v.hold > 0) begin
      hold_left = v.hold;
      repeat (v.hold) cycle();
      chk("hold_issued", issued, v.exp_hold_issued);
    end
    n = 0;
    while (n < 3000 && !(done_cnt > 0 && exp_dout_q.size() == 0
                         && resp_q.size() == 0)) begin
      cycle();
      if (done_cnt > 0) cmd_valid = 1'b0;
      n++;
    end
    cmd_valid = 1'b0;
    chk("burst_complete",
        (done_cnt > 0 && exp_dout_q.size() == 0), 1);
    chk("done_pulses", done_cnt, 1);
    chk("accepts", acc_cnt, 1);
    chk("accesses", issued, v.len);
    chk("cmd_ready_after", cmd_ready, 1);
    chk("active_after", active, 0);
    if (v.len == 0) begin
      chk("len0_done_latency", done_cyc - acc_cyc, 1);
    end else if (v.busy_pct == 0) begin
      chk("first_issue_latency", first_issue_cyc - acc_cyc, 1);
    end
    exp_addr_q.delete();
    exp_dout_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_in_valid"}, in_valid, 0);
    chk({tag, "_dout_valid"}, dout_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_rw"}, rw, 0);
    chk({tag, "_data_in"}, data_in, 0);
  endtask

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    cmd_data   = '0;
    busy       = 1'b0;
    data_out   = '0;
    out_valid  = 1'b0;
    dout_ready = 1'b0;
    clear_burst();

    //      op    addr         len data          busy rdy hold exp keep
    vt[0] = '{1'b0, 23'h000100, 8, 32'h0,        0, 100, 0, 0, 1'b0};
    vt[1] = '{1'b0, 23'h000200, 16, 32'h0,       0, 100, 20, 4, 1'b0};
    vt[2] = '{1'b1, 23'h7FFFFE, 4, 32'hDEADBEEF, 0, 100, 0, 0, 1'b0};
    vt[3] = '{1'b0, 23'h7FFFFE, 4, 32'h0,        0, 100, 0, 0, 1'b0};
    vt[4] = '{1'b0, 23'h000300, 32, 32'h0,       50, 70, 0, 0, 1'b0};
    vt[5] = '{1'b0, 23'h000400, 0, 32'h0,        0, 100, 0, 0, 1'b1};
    vt[6] = '{1'b1, 23'h000500, 6, 32'h12345678, 50, 100, 0, 0, 1'b1};
    vt[7] = '{1'b0, 23'h000500, 6, 32'h0,        30, 50, 0, 0, 1'b1};
    vt[8] = '{1'b0, 23'h7FFFFC, 10, 32'h0,       0, 40, 6, 4, 1'b0};
    vt[9] = '{1'b1, 23'h000010, 0, 32'hFFFFFFFF, 0, 100, 0, 0, 1'b0};
    for (int i = 10; i < 30; i++) begin
      vt[i].op   = 1'($urandom_range(1));
      vt[i].addr = ($urandom_range(3) == 0)
                 ? 23'h7FFFFF - 23'($urandom_range(15))
                 : 23'($urandom);
      vt[i].len  = $urandom_range(24);
      vt[i].data = $urandom;
      vt[i].busy_pct  = $urandom_range(60);
      vt[i].ready_pct = $urandom_range(100, 20);
      vt[i].hold = 0;
      vt[i].exp_hold_issued = 0;
      vt[i].keep_valid = 1'($urandom_range(1));
    end

    #2;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      run_cmd(vt[i]);
      repeat (2) cycle();
    end

    // Reset mid-READ with two reads outstanding, then stale returns.
    clear_burst();
    lat = 4;
    busy_pct = 0;
    ready_pct = 0;
    hold_left = 0;
    cur_op = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_addr = 23'h000600;
    cmd_len = 16'd8;
    for (int n = 0; n < 20 && acc_cnt == 0; n++) cycle();
    cmd_valid = 1'b0;
    repeat (2) cycle();
    chk("pre_reset_issued", issued, 2);
    rst = 1'b1;
    exp_addr_q.delete();
    exp_dout_q.delete();
    #1;
    chk_reset_outputs("midreset");
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) cycle();
    chk("stale_returns_consumed", resp_q.size(), 0);
    chk("late_return_dout_valid", dout_valid, 0);
    chk("late_return_cmd_ready", cmd_ready, 1);
    chk("late_return_active", active, 0);
    lat = 1;
    run_cmd('{1'b0, 23'h000600, 8, 32'h0, 20, 80, 0, 0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
